// File: rtl/maxpool_3x3_s2.sv
// 3x3 stride-2 max-pooling engine for one feature-map channel.
// Walks the input map window by window, issuing one bank read address per
// cycle, and folds the returning samples into a signed running maximum.
module maxpool_3x3_s2 #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 32,
  parameter int IN_DIM  = 111,
  parameter int OUT_DIM = 55,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] datain,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] output_im,
  output logic              o_max_data_valid,
  output logic              o_done
);

  localparam int CW    = $clog2(OUT_DIM);
  localparam int TOTAL = OUT_DIM * OUT_DIM;
  localparam int OCW   = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;

  // Window position (row/col) and tap position (ti/tj) of the address being presented
  logic [CW-1:0]     row_reg, row_next, col_reg, col_next;
  logic [1:0]        ti_reg, ti_next, tj_reg, tj_next;
  logic              issued_all_reg, issued_all_next;
  logic [ADDR_W-1:0] address_reg, address_next;

  logic signed [DATA_W-1:0] acc_reg, acc_next, tap_max, datain_s;
  logic [DATA_W-1:0] output_im_reg, output_im_next;
  logic              strobe_reg, strobe_next;
  logic [OCW-1:0]    out_cnt_reg, out_cnt_next;

  // Tap tags {valid, first, last} travel alongside the read so they line up with datain
  logic              issue_vld, issue_first, issue_last, clear_all;
  logic [RD_LAT-1:0][2:0] meta_in, meta_pipe_reg;
  logic              tap_vld, tap_first, tap_last;

  assign datain_s = datain;
  assign meta_in[0] = {issue_vld, issue_first, issue_last};

  genvar gi;
  generate
    for (gi = 1; gi < RD_LAT; gi++) begin : g_meta_chain
      assign meta_in[gi] = meta_pipe_reg[gi-1];
    end
  endgenerate

  assign {tap_vld, tap_first, tap_last} = meta_pipe_reg[RD_LAT-1];
  assign tap_max = (datain_s > acc_reg) ? datain_s : acc_reg;

  // Delay line for tap tags; flushed on abort so stale reads are never folded in
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      meta_pipe_reg <= '0;
    end else begin
      meta_pipe_reg <= meta_in;
    end
  end

  // Next-state, address walk, running max and output strobe
  always_comb begin
    state_next      = state_reg;
    row_next        = row_reg;
    col_next        = col_reg;
    ti_next         = ti_reg;
    tj_next         = tj_reg;
    issued_all_next = issued_all_reg;
    acc_next        = acc_reg;
    output_im_next  = output_im_reg;
    strobe_next     = 1'b0;
    out_cnt_next    = out_cnt_reg;
    issue_vld       = 1'b0;
    issue_first     = 1'b0;
    issue_last      = 1'b0;
    clear_all       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_data_valid) state_next = RUN;
      end
      RUN: begin
        if (!i_data_valid) begin
          state_next = IDLE;
          clear_all  = 1'b1;
        end else begin
          if (!issued_all_reg) begin
            issue_vld   = 1'b1;
            issue_first = (ti_reg == 2'd0) && (tj_reg == 2'd0);
            issue_last  = (ti_reg == 2'd2) && (tj_reg == 2'd2);
            // Last tap of last window: freeze counters so address holds it
            if (row_reg == CW'(OUT_DIM-1) && col_reg == CW'(OUT_DIM-1) && issue_last) begin
              issued_all_next = 1'b1;
            end else if (tj_reg != 2'd2) begin
              tj_next = tj_reg + 2'd1;
            end else begin
              tj_next = 2'd0;
              if (ti_reg != 2'd2) begin
                ti_next = ti_reg + 2'd1;
              end else begin
                ti_next = 2'd0;
                if (col_reg != CW'(OUT_DIM-1)) begin
                  col_next = col_reg + CW'(1);
                end else begin
                  col_next = '0;
                  row_next = row_reg + CW'(1);
                end
              end
            end
          end
          if (tap_vld) begin
            acc_next = tap_first ? datain_s : tap_max;
            if (tap_last) begin
              output_im_next = acc_next;
              strobe_next    = 1'b1;
              out_cnt_next   = out_cnt_reg + OCW'(1);
            end
          end
          if (strobe_reg && out_cnt_reg == OCW'(TOTAL)) state_next = DONE;
        end
      end
      DONE: begin
        if (!i_data_valid) begin
          state_next = IDLE;
          clear_all  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (clear_all) begin
      row_next        = '0;
      col_next        = '0;
      ti_next         = '0;
      tj_next         = '0;
      issued_all_next = 1'b0;
      acc_next        = '0;
      out_cnt_next    = '0;
    end

    address_next = (ADDR_W'(row_next) * ADDR_W'(2) + ADDR_W'(ti_next)) * ADDR_W'(IN_DIM)
                 + ADDR_W'(col_next) * ADDR_W'(2) + ADDR_W'(tj_next);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      row_reg        <= '0;
      col_reg        <= '0;
      ti_reg         <= '0;
      tj_reg         <= '0;
      issued_all_reg <= 1'b0;
      address_reg    <= '0;
      acc_reg        <= '0;
      output_im_reg  <= '0;
      strobe_reg     <= 1'b0;
      out_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      row_reg        <= row_next;
      col_reg        <= col_next;
      ti_reg         <= ti_next;
      tj_reg         <= tj_next;
      issued_all_reg <= issued_all_next;
      address_reg    <= address_next;
      acc_reg        <= acc_next;
      output_im_reg  <= output_im_next;
      strobe_reg     <= strobe_next;
      out_cnt_reg    <= out_cnt_next;
    end
  end

  assign address          = address_reg;
  assign output_im        = output_im_reg;
  assign o_max_data_valid = strobe_reg;
  assign o_done           = (state_reg == DONE);

endmodule

// File: tb/tb_maxpool_3x3_s2.sv
// Scoreboard bench for maxpool_3x3_s2: expected window maxima and strobe
// cycles are queued when a run is started and popped on every output strobe.
module tb_maxpool_3x3_s2;
  localparam int IN    = 111;
  localparam int OUT   = 55;
  localparam int TOTAL = OUT * OUT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_data_valid = 1'b0;
  logic [15:0] datain = '0;
  logic [31:0] address;
  logic [15:0] output_im;
  logic        o_max_data_valid;
  logic        o_done;

  maxpool_3x3_s2 dut (
    .clk              (clk),
    .rst              (rst),
    .i_data_valid     (i_data_valid),
    .datain           (datain),
    .address          (address),
    .output_im        (output_im),
    .o_max_data_valid (o_max_data_valid),
    .o_done           (o_done)
  );

  always #5 clk = ~clk;

  // Bank model with one cycle of read latency
  logic [15:0] mem [0:IN*IN-1];
  always @(posedge clk) datain <= mem[address];

  typedef struct {
    logic [15:0] val;
    int          cyc;
    int          idx;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Output monitor: each strobe is one transaction
  always @(negedge clk) begin
    if (o_max_data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_strobe_queue", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        $display("strobe win=%0d cyc=%0d value=%h expect=%h @%0d", e.idx, cyc - start, output_im, e.val, e.cyc - start);
        check("strobe_value", 32'(output_im), 32'(e.val));
        check("strobe_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic logic [15:0] win_max(input int n);
    int r, c;
    logic signed [15:0] m, v;
    r = n / OUT;
    c = n % OUT;
    m = mem[(2*r)*IN + 2*c];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        v = mem[(2*r+i)*IN + 2*c + j];
        if (v > m) m = v;
      end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_windows(input int nwin);
    start = cyc + 1;
    for (int n = 0; n < nwin; n++) sb.push_back('{win_max(n), start + 9*n + 10, n});
  endtask

  // Run with nwin complete windows expected, dropping i_data_valid during cycle stop_rel
  task automatic run_windows(input int nwin, input int stop_rel);
    push_windows(nwin);
    i_data_valid = 1'b1;
    tick();
    while (cyc - start < stop_rel) tick();
    i_data_valid = 1'b0;
    tick();
    check("abort_address", address, 32'd0);
    check("abort_valid", 32'(o_max_data_valid), 32'd0);
    repeat (12) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic fill_linear();
    for (int a = 0; a < IN*IN; a++) mem[a] = 16'(a);
  endtask

  initial begin
    bit seen;
    logic [15:0] sgn [9];
    fill_linear();
    repeat (2) tick();
    rst = 1'b0;
    check("reset_address", address, 32'd0);
    check("reset_output", 32'(output_im), 32'd0);
    check("reset_valid", 32'(o_max_data_valid), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);

    // Full sweep over mem[a]=a
    push_windows(TOTAL);
    i_data_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30000; k++) begin
      tick();
      if (o_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("done_cycle", 32'(cyc), 32'(start + 9*(TOTAL-1) + 11));
    check("done_address", address, 32'd12320);
    check("full_sb_drained", 32'(sb.size()), 32'd0);
    repeat (5) tick();
    check("done_hold", 32'(o_done), 32'd1);
    check("done_addr_hold", address, 32'd12320);
    i_data_valid = 1'b0;
    tick();
    check("done_exit", 32'(o_done), 32'd0);
    check("done_exit_addr", address, 32'd0);
    repeat (3) tick();

    // Abort in cycle 5, then restart
    run_windows(0, 5);
    run_windows(1, 12);

    // Reset during cycle 14 with enable still high
    push_windows(1);
    i_data_valid = 1'b1;
    tick();
    while (cyc - start < 14) tick();
    rst = 1'b1;
    tick();
    check("rst_address", address, 32'd0);
    check("rst_output", 32'(output_im), 32'd0);
    check("rst_valid", 32'(o_max_data_valid), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    rst = 1'b0;
    run_windows(2, 20);

    // Signed window: -5,-3,-9,-1,-7,-2,-8,-4,-6
    sgn = '{16'hFFFB, 16'hFFFD, 16'hFFF7, 16'hFFFF, 16'hFFF9, 16'hFFFE, 16'hFFF8, 16'hFFFC, 16'hFFFA};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) mem[i*IN + j] = sgn[i*3 + j];
    run_windows(2, 20);

    // Extremes: all 0x7FFF but one 0x8000
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) mem[i*IN + j] = 16'h7FFF;
    mem[IN + 1] = 16'h8000;
    run_windows(1, 12);

    // Constant memory
    for (int a = 0; a < IN*IN; a++) mem[a] = 16'h0042;
    run_windows(4, 40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
